// File: rtl/sm83_regfile.sv
// SM83 register file with the 16-bit increment/decrement unit.
// Drives the address bus, data-bus source byte and flags.
module sm83_regfile #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] SP_RESET = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [2:0]  s_ab,
  input  logic [3:0]  s_db,
  input  logic [3:0]  t_db,
  input  logic [7:0]  db_wdata,
  input  logic [1:0]  idu_mode,
  input  logic [1:0]  s_rr_wb,
  input  logic [2:0]  t_rr_wb,
  input  logic        wr_pc,
  input  logic        alu_carry,
  input  logic        flags_we,
  input  logic [3:0]  flags_in,
  output logic [15:0] addr,
  output logic [7:0]  db_out,
  output logic [3:0]  flags,
  output logic [7:0]  a_out,
  output logic [7:0]  spl_out,
  output logic [7:0]  sph_out,
  output logic [7:0]  pcl_out
);

  localparam logic [3:0] R_Z   = 4'd1;
  localparam logic [3:0] R_SPH = 4'd9;
  localparam logic [3:0] R_SPL = 4'd10;
  localparam logic [3:0] R_PCH = 4'd11;
  localparam logic [3:0] R_PCL = 4'd12;
  localparam logic [3:0] R_A   = 4'd13;
  localparam logic [3:0] R_NIL = 4'd14;
  localparam logic [3:0] R_F   = 4'd15;

  localparam logic [1:0] IDU_INC = 2'd0;
  localparam logic [1:0] IDU_DEC = 2'd1;
  localparam logic [1:0] IDU_ADJ = 2'd2;

  localparam logic [1:0] WB_IDU = 2'd1;
  localparam logic [1:0] WB_WZ  = 2'd2;

  // Indexed by the reg8 code; slots 0 (MEM) and 14 are never written.
  logic [7:0] r_q [16];
  logic [7:0] r_d [16];

  function automatic logic [3:0] hi_idx(input logic [2:0] sel);
    unique case (sel)
      3'd0:    return 4'd2;
      3'd1:    return 4'd3;
      3'd2:    return 4'd5;
      3'd3:    return 4'd7;
      3'd4:    return R_A;
      3'd5:    return R_SPH;
      default: return R_PCH;
    endcase
  endfunction

  // PCH_ZERO maps its low byte to slot 0, which always reads zero.
  function automatic logic [3:0] lo_idx(input logic [2:0] sel);
    unique case (sel)
      3'd0:    return R_Z;
      3'd1:    return 4'd4;
      3'd2:    return 4'd6;
      3'd3:    return 4'd8;
      3'd4:    return R_F;
      3'd5:    return R_SPL;
      3'd6:    return R_PCL;
      default: return 4'd0;
    endcase
  endfunction

  logic [15:0] idu;
  logic [7:0]  adj_hi;
  logic [15:0] rr_val;
  logic [3:0]  wb_hi;
  logic [3:0]  wb_lo;

  assign addr = {r_q[hi_idx(s_ab)], r_q[lo_idx(s_ab)]};

  always_comb begin
    adj_hi = addr[15:8];
    if (alu_carry && !r_q[R_Z][7]) begin
      adj_hi = addr[15:8] + 8'd1;
    end else if (!alu_carry && r_q[R_Z][7]) begin
      adj_hi = addr[15:8] - 8'd1;
    end
    unique case (idu_mode)
      IDU_INC: idu = addr + 16'd1;
      IDU_DEC: idu = addr - 16'd1;
      IDU_ADJ: idu = {adj_hi, addr[7:0]};
      default: idu = addr;
    endcase
  end

  assign rr_val = (s_rr_wb == WB_WZ) ? {r_q[2], r_q[1]} : idu;
  assign wb_hi  = hi_idx(t_rr_wb);
  assign wb_lo  = lo_idx(t_rr_wb);

  // Applied lowest priority first so later writes win per byte.
  always_comb begin
    for (int i = 0; i < 16; i++) r_d[i] = r_q[i];
    if (t_db == R_F) begin
      r_d[R_F] = {db_wdata[7:4], 4'h0};
    end else if (t_db != 4'd0 && t_db != R_NIL) begin
      r_d[t_db] = db_wdata;
    end
    if (flags_we) r_d[R_F] = {flags_in, 4'h0};
    if ((s_rr_wb == WB_IDU || s_rr_wb == WB_WZ) && t_rr_wb != 3'd7) begin
      r_d[wb_hi] = rr_val[15:8];
      if (idu_mode != IDU_ADJ) begin
        r_d[wb_lo] = (wb_lo == R_F) ? {rr_val[7:4], 4'h0} : rr_val[7:0];
      end
    end
    if (wr_pc) begin
      r_d[R_PCH] = idu[15:8];
      r_d[R_PCL] = idu[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_q[i] <= 8'h00;
      r_q[R_SPH] <= SP_RESET[15:8];
      r_q[R_SPL] <= SP_RESET[7:0];
      r_q[R_PCH] <= PC_RESET[15:8];
      r_q[R_PCL] <= PC_RESET[7:0];
    end else if (ce) begin
      for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
    end
  end

  assign db_out  = r_q[s_db];
  assign flags   = r_q[R_F][7:4];
  assign a_out   = r_q[R_A];
  assign spl_out = r_q[R_SPL];
  assign sph_out = r_q[R_SPH];
  assign pcl_out = r_q[R_PCL];

endmodule

// File: doc/sm83_regfile.md
Name: sm83_regfile

Overview:
- Register file plus 16-bit increment/decrement unit (IDU) for the SM83 core.
- Sits directly downstream of the instruction decoder. It consumes the per-step select/writeback controls and drives the address bus, the data-bus source value and the flags seen by the sequencer and ALU.
- Holds A, F, B, C, D, E, H, L, SPH, SPL, PCH, PCL and the temporaries W, Z.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.
- SP_RESET, 16'hFFFE, SP value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  step enable; when low, no state changes (memory wait state).
- s_ab  in  3  reg16 select for address bus and IDU input: WZ=0, BC=1, DE=2, HL=3, AF=4, SP=5, PC=6, PCH_ZERO=7.
- s_db  in  4  reg8 source for db_out: MEM=0, Z=1, W=2, B=3, C=4, D=5, E=6, H=7, L=8, SPH=9, SPL=10, PCH=11, PCL=12, A=13, F=15.
- t_db  in  4  reg8 target for db_wdata (same encoding); MEM=0 means no register write.
- db_wdata  in  8  value to write to t_db (ALU result or transferred byte, muxed upstream).
- idu_mode  in  2  INC=0, DEC=1, ADJ=2, 3 = pass-through.
- s_rr_wb  in  2  NONE=0, IDU=1, WZ=2.
- t_rr_wb  in  3  reg16 writeback target (reg16 encoding).
- wr_pc  in  1  latch PC from IDU output.
- alu_carry  in  1  carry out of the current ALU op (used by ADJ).
- flags_we  in  1  write flags_in to F[7:4].
- flags_in  in  4  {z,n,h,c}.
- addr  out  16  address bus.
- db_out  out  8  value of s_db register (0 when s_db=MEM or 14).
- flags  out  4  F[7:4] as {z,n,h,c}.
- a_out  out  8  accumulator, for the ALU.
- spl_out, sph_out, pcl_out  out  8 each  ALU accumulator alternates.

Behaviour:
- Reset (rst=1 at clk edge, overrides ce):
  - PC=PC_RESET, SP=SP_RESET; all other registers 0.
  - Thereafter addr = PC_RESET when s_ab=PC; flags = 0.
- addr is combinational from s_ab.
  - PCH_ZERO gives {PCH,8'h00}.
  - AF gives {A,F}.
- IDU is combinational on addr:
  - INC: addr+1, mod 2^16 (FFFF→0000).
  - DEC: addr-1, mod 2^16 (0000→FFFF).
  - pass-through: addr.
  - ADJ: the result high byte is addr[15:8] adjusted by the current ALU op: +1 if alu_carry=1 and Z[7]=0; −1 (mod 256) if alu_carry=0 and Z[7]=1; otherwise unchanged. The result low byte is don't-care.
- Writes happen only on the rising clk edge with ce=1 and rst=0. Zero-latency model: writes are visible on outputs the cycle after the edge.
- db write:
  - t_db≠MEM writes db_wdata to the named register.
  - t_db=F writes {db_wdata[7:4],4'b0}.
  - t_db=14 is ignored.
- 16-bit writeback:
  - s_rr_wb=IDU writes the IDU result to t_rr_wb.
  - s_rr_wb=WZ writes {W,Z}, using pre-edge values, to t_rr_wb.
  - In ADJ mode only the high byte of t_rr_wb is written.
  - Writes to AF force F[3:0]=0.
  - t_rr_wb=PCH_ZERO is ignored.
- wr_pc=1 writes the IDU result to PC.
- flags_we=1 writes flags_in to F[7:4].
- Priority per byte, highest first:
  1. wr_pc (PC bytes only)
  2. 16-bit writeback
  3. flags_we (F only)
  4. db write
  Example: t_db=Z with ADJ writeback to WZ writes Z from db_wdata and W from the IDU, with no conflict.
- F[3:0] reads 0 at all times.
- ce=0: all registers hold; outputs stay combinationally valid.

Test Plan:
- Reset then NOP-style step (s_ab=PC, INC, wr_pc=1), 3 cycles → addr goes 0000, 0001, 0002, 0003.
- PC wrap: force PC=FFFF via WZ writeback ({W,Z}=FFFF, t_rr_wb=PC), then INC+wr_pc → addr=0000. SP=0000 with DEC writeback to SP → SP=FFFF.
- LD (HL+)-style step: HL=C0FF, s_ab=HL, INC, s_rr_wb=IDU, t_rr_wb=HL → addr=C0FF this cycle, HL=C100 next.
- JR adjust: PC=12F0, Z=20. Step with s_ab=PCH_ZERO, ADJ, alu_carry=1, t_db=Z, db_wdata=10, writeback WZ → W=13, Z=10. Repeat with Z=F0, alu_carry=0 → W=11.
- POP AF-style: W=12, Z=FF, s_rr_wb=WZ, t_rr_wb=AF → A=12, F=F0, flags=F. Simultaneous flags_we=1 with flags_in=0 → F still F0 (writeback wins).
- ce=0 with wr_pc=1, t_db=A, db_wdata=55 → PC and A unchanged. rst=1 in the same cycle as ce=1 writes → all registers at reset values.
